// File: rtl/fu_pkg.sv
// ----------------------------------------------------------------------------
// fu_pkg: FS encodings, flag indices and arbiter FSM state shared by fu_arbiter.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fu_pkg;

  localparam logic [4:0] FS_ADD = 5'b00010;
  localparam logic [4:0] FS_SUB = 5'b00101;
  localparam logic [4:0] FS_AND = 5'b01000;
  localparam logic [4:0] FS_SHL = 5'b10000;
  localparam logic [4:0] FS_SHR = 5'b10001;

  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  fs;
    logic [4:0]  sh;
  } fu_op_t;

  function automatic logic [3:0] pack_flags(input logic v, input logic c,
                                            input logic n, input logic z);
    logic [3:0] flags;
    flags         = '0;
    flags[FLAG_V] = v;
    flags[FLAG_C] = c;
    flags[FLAG_N] = n;
    flags[FLAG_Z] = z;
    return flags;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fu_arbiter_fu.sv
// ----------------------------------------------------------------------------
// FunctionUnit: 32-bit arithmetic / logic / barrel-shift unit with V,C,N,Z
// flags and shifter carry-outs. FS[4:3]: 00 arith, 01 logic, 1x shift. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module FunctionUnit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  fs,
  input  logic [4:0]  sh,
  output logic [31:0] f,
  output logic        v,
  output logic        c,
  output logic        n,
  output logic        z,
  output logic        lco,
  output logic        rco
);

  logic [31:0] bsel;
  logic [32:0] sum;
  logic [32:0] lsh;
  logic [32:0] rsh;

  always_comb begin
    f    = '0;
    v    = 1'b0;
    c    = 1'b0;
    lco  = 1'b0;
    rco  = 1'b0;
    bsel = '0;
    sum  = '0;
    lsh  = '0;
    rsh  = '0;
    case (fs[4:3])
      2'b00: begin
        // Arithmetic: F = A + Bsel + FS[0], Bsel chosen by FS[2:1].
        case (fs[2:1])
          2'b00:   bsel = '0;
          2'b01:   bsel = b;
          2'b10:   bsel = ~b;
          default: bsel = '1;
        endcase
        sum = {1'b0, a} + {1'b0, bsel} + {32'd0, fs[0]};
        f   = sum[31:0];
        c   = sum[32];
        v   = (a[31] == bsel[31]) && (sum[31] != a[31]);
      end
      2'b01: begin
        case (fs[2:1])
          2'b00:   f = a & b;
          2'b01:   f = a | b;
          2'b10:   f = a ^ b;
          default: f = ~a;
        endcase
      end
      default: begin
        // The extra bit of each 33-bit shift catches the last bit shifted out.
        if (!fs[0]) begin
          lsh = {1'b0, a} << sh;
          f   = lsh[31:0];
          lco = lsh[32];
        end else begin
          rsh = {a, 1'b0} >> sh;
          f   = rsh[32:1];
          rco = rsh[0];
        end
      end
    endcase
    n = f[31];
    z = (f == 32'd0);
  end

endmodule

`default_nettype wire

// File: rtl/fu_arbiter.sv
// ----------------------------------------------------------------------------
// fu_arbiter: shares one FunctionUnit between two valid/ready requesters.
// Macro FU_ARB_STICKY_FLAGS_EN adds sticky_clr / sticky_vc. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fu_arbiter
  import fu_pkg::*;
#(
  parameter int PRIO_FIXED = 0,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [4:0]       req0_fs,
  input  logic [4:0]       req0_sh,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [4:0]       req1_fs,
  input  logic [4:0]       req1_sh,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      rsp_f,
  output logic [3:0]       rsp_flags,
  output logic             rsp_lco,
  output logic             rsp_rco
`ifdef FU_ARB_STICKY_FLAGS_EN
  ,
  input  logic             sticky_clr,
  output logic [1:0]       sticky_vc
`endif
);

  arb_state_e       state;
  logic             last_grant;
  fu_op_t           op;
  logic [TAG_W-1:0] op_tag;
  logic             op_id;
  logic             grant0;
  logic             grant1;

  logic [31:0] fu_f;
  logic        fu_v;
  logic        fu_c;
  logic        fu_n;
  logic        fu_z;
  logic        fu_lco;
  logic        fu_rco;

  // Round-robin favours requester 0 whenever requester 1 was served last.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || (PRIO_FIXED != 0) || last_grant);
    grant1 = req1_valid && !grant0;
  end

  assign req0_ready = (state == ST_IDLE) && grant0;
  assign req1_ready = (state == ST_IDLE) && grant1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      op         <= '0;
      op_tag     <= '0;
      op_id      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_tag    <= '0;
      rsp_f      <= '0;
      rsp_flags  <= '0;
      rsp_lco    <= 1'b0;
      rsp_rco    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req0_ready) begin
            op         <= '{a: req0_a, b: req0_b, fs: req0_fs, sh: req0_sh};
            op_tag     <= req0_tag;
            op_id      <= 1'b0;
            last_grant <= 1'b0;
            state      <= ST_EXEC;
          end else if (req1_ready) begin
            op         <= '{a: req1_a, b: req1_b, fs: req1_fs, sh: req1_sh};
            op_tag     <= req1_tag;
            op_id      <= 1'b1;
            last_grant <= 1'b1;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_f     <= fu_f;
          rsp_flags <= pack_flags(fu_v, fu_c, fu_n, fu_z);
          rsp_lco   <= fu_lco;
          rsp_rco   <= fu_rco;
          rsp_tag   <= op_tag;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FU_ARB_STICKY_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_vc <= 2'b00;
    end else if (sticky_clr) begin
      sticky_vc <= 2'b00;
    end else if (state == ST_EXEC) begin
      sticky_vc <= sticky_vc | {fu_v, fu_c};
    end
  end
`endif

  FunctionUnit u_fu (
    .a   (op.a),
    .b   (op.b),
    .fs  (op.fs),
    .sh  (op.sh),
    .f   (fu_f),
    .v   (fu_v),
    .c   (fu_c),
    .n   (fu_n),
    .z   (fu_z),
    .lco (fu_lco),
    .rco (fu_rco)
  );

endmodule

`default_nettype wire

// File: tb/tb_fu_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fu_arbiter: directed bench for fu_arbiter (round-robin and fixed-priority
// instances). Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fu_arbiter;
  import fu_pkg::*;

  localparam int TAG_W = 4;

  logic             clk;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic [31:0]      req0_a, req0_b, req1_a, req1_b;
  logic [4:0]       req0_fs, req0_sh, req1_fs, req1_sh;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic             rsp_ready;

  logic             req0_ready, req1_ready, rsp_valid, rsp_id, rsp_lco, rsp_rco;
  logic [TAG_W-1:0] rsp_tag;
  logic [31:0]      rsp_f;
  logic [3:0]       rsp_flags;

  logic             fx_req0_ready, fx_req1_ready, fx_rsp_valid, fx_rsp_id, fx_rsp_lco, fx_rsp_rco;
  logic [TAG_W-1:0] fx_rsp_tag;
  logic [31:0]      fx_rsp_f;
  logic [3:0]       fx_rsp_flags;

`ifdef FU_ARB_STICKY_FLAGS_EN
  logic             sticky_clr;
  logic [1:0]       sticky_vc, fx_sticky_vc;
`endif

  wire [43:0] rsp_all = {rsp_valid, rsp_id, rsp_tag, rsp_flags, rsp_lco, rsp_rco, rsp_f};

  int n_cmp = 0;
  int n_bad = 0;

  fu_arbiter #(.PRIO_FIXED(0), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_fs(req0_fs), .req0_sh(req0_sh), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_fs(req1_fs), .req1_sh(req1_sh), .req1_tag(req1_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
    .rsp_f(rsp_f), .rsp_flags(rsp_flags), .rsp_lco(rsp_lco), .rsp_rco(rsp_rco)
`ifdef FU_ARB_STICKY_FLAGS_EN
    , .sticky_clr(sticky_clr), .sticky_vc(sticky_vc)
`endif
  );

  fu_arbiter #(.PRIO_FIXED(1), .TAG_W(TAG_W)) dut_fx (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(fx_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_fs(req0_fs), .req0_sh(req0_sh), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(fx_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_fs(req1_fs), .req1_sh(req1_sh), .req1_tag(req1_tag),
    .rsp_valid(fx_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fx_rsp_id), .rsp_tag(fx_rsp_tag),
    .rsp_f(fx_rsp_f), .rsp_flags(fx_rsp_flags), .rsp_lco(fx_rsp_lco), .rsp_rco(fx_rsp_rco)
`ifdef FU_ARB_STICKY_FLAGS_EN
    , .sticky_clr(sticky_clr), .sticky_vc(fx_sticky_vc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] fs, input logic [4:0] sh, input logic [TAG_W-1:0] tag);
    req0_valid = v; req0_a = a; req0_b = b; req0_fs = fs; req0_sh = sh; req0_tag = tag;
  endtask

  task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] fs, input logic [4:0] sh, input logic [TAG_W-1:0] tag);
    req1_valid = v; req1_a = a; req1_b = b; req1_fs = fs; req1_sh = sh; req1_tag = tag;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive0(1'b0, '0, '0, '0, '0, '0);
    drive1(1'b0, '0, '0, '0, '0, '0);
    rsp_ready = 1'b0;
`ifdef FU_ARB_STICKY_FLAGS_EN
    sticky_clr = 1'b0;
`endif
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rsp_all !== 44'd0) begin
      $display("FAIL reset_rsp: got %h want %h", rsp_all, 44'd0); n_bad++;
    end
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready}); n_bad++;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    do_reset();
    drive0(1'b1, 32'h7FFF_FFFF, 32'd1, FS_ADD, 5'd0, 4'd3);
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      $display("FAIL add_ready: got %b want 10", {req0_ready, req1_ready}); n_bad++;
    end
    tick();
    drive0(1'b0, '0, '0, '0, '0, '0);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      $display("FAIL add_exec_valid: got %b want 0", rsp_valid); n_bad++;
    end
    tick();
    n_cmp++;
    if (rsp_all !== {1'b1, 1'b0, 4'd3, 4'b1010, 1'b0, 1'b0, 32'h8000_0000}) begin
      $display("FAIL add_rsp: got %h want %h", rsp_all,
               {1'b1, 1'b0, 4'd3, 4'b1010, 1'b0, 1'b0, 32'h8000_0000}); n_bad++;
    end
    rsp_ready = 1'b1;
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      $display("FAIL add_rsp_done: got %b want 0", rsp_valid); n_bad++;
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_contention();
    do_reset();
    drive0(1'b1, 32'd5, 32'd5, FS_SUB, 5'd0, 4'd1);
    drive1(1'b1, 32'hF0, 32'h0F, FS_AND, 5'd0, 4'd2);
    rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      $display("FAIL cont_first_grant: got %b want 10", {req0_ready, req1_ready}); n_bad++;
    end
    tick();
    req0_valid = 1'b0;
    tick();
    n_cmp++;
    if (rsp_all !== {1'b1, 1'b0, 4'd1, 4'b0101, 1'b0, 1'b0, 32'd0}) begin
      $display("FAIL cont_rsp0: got %h want %h", rsp_all,
               {1'b1, 1'b0, 4'd1, 4'b0101, 1'b0, 1'b0, 32'd0}); n_bad++;
    end
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      $display("FAIL cont_busy_ready: got %b want 00", {req0_ready, req1_ready}); n_bad++;
    end
    tick();
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      $display("FAIL cont_second_grant: got %b want 01", {req0_ready, req1_ready}); n_bad++;
    end
    tick();
    req1_valid = 1'b0;
    tick();
    n_cmp++;
    if (rsp_all !== {1'b1, 1'b1, 4'd2, 4'b0001, 1'b0, 1'b0, 32'd0}) begin
      $display("FAIL cont_rsp1: got %h want %h", rsp_all,
               {1'b1, 1'b1, 4'd2, 4'b0001, 1'b0, 1'b0, 32'd0}); n_bad++;
    end
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_shift();
    do_reset();
    drive1(1'b1, 32'h8000_0001, 32'd0, FS_SHL, 5'd1, 4'hA);
    rsp_ready = 1'b1;
    tick();
    drive1(1'b1, 32'h0000_000F, 32'd0, FS_SHR, 5'd4, 4'hB);
    tick();
    n_cmp++;
    if (rsp_all !== {1'b1, 1'b1, 4'hA, 4'b0000, 1'b1, 1'b0, 32'h0000_0002}) begin
      $display("FAIL shl_rsp: got %h want %h", rsp_all,
               {1'b1, 1'b1, 4'hA, 4'b0000, 1'b1, 1'b0, 32'h0000_0002}); n_bad++;
    end
    tick();
    tick();
    req1_valid = 1'b0;
    tick();
    n_cmp++;
    if (rsp_all !== {1'b1, 1'b1, 4'hB, 4'b0001, 1'b0, 1'b1, 32'd0}) begin
      $display("FAIL shr_rsp: got %h want %h", rsp_all,
               {1'b1, 1'b1, 4'hB, 4'b0001, 1'b0, 1'b1, 32'd0}); n_bad++;
    end
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    drive0(1'b1, 32'h1234_5678, 32'h1111_1111, FS_ADD, 5'd0, 4'd5);
    drive1(1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, FS_AND, 5'd0, 4'd6);
    tick();
    req0_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (rsp_all !== {1'b1, 1'b0, 4'd5, 4'b0000, 1'b0, 1'b0, 32'h2345_6789}) begin
        $display("FAIL stall_rsp[%0d]: got %h want %h", i, rsp_all,
                 {1'b1, 1'b0, 4'd5, 4'b0000, 1'b0, 1'b0, 32'h2345_6789}); n_bad++;
      end
      n_cmp++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
        $display("FAIL stall_ready[%0d]: got %b want 00", i, {req0_ready, req1_ready}); n_bad++;
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    n_cmp++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b001) begin
      $display("FAIL stall_release: got %b want 001", {rsp_valid, req0_ready, req1_ready}); n_bad++;
    end
    tick();
    req1_valid = 1'b0;
    tick();
    n_cmp++;
    if (rsp_all !== {1'b1, 1'b1, 4'd6, 4'b0010, 1'b0, 1'b0, 32'hF000_F000}) begin
      $display("FAIL stall_pending_rsp: got %h want %h", rsp_all,
               {1'b1, 1'b1, 4'd6, 4'b0010, 1'b0, 1'b0, 32'hF000_F000}); n_bad++;
    end
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int got;
    do_reset();
    drive0(1'b1, 32'd1, 32'd1, FS_ADD, 5'd0, 4'd1);
    drive1(1'b1, 32'd2, 32'd2, FS_ADD, 5'd0, 4'd2);
    rsp_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      tick();
      if (rsp_valid) begin
        n_cmp++;
        if (rsp_id !== got[0]) begin
          $display("FAIL rr_id[%0d]: got %b want %b", got, rsp_id, got[0]); n_bad++;
        end
        n_cmp++;
        if (fx_rsp_id !== 1'b0) begin
          $display("FAIL fixed_id[%0d]: got %b want 0", got, fx_rsp_id); n_bad++;
        end
        got++;
      end
    end
    n_cmp++;
    if (got !== 10) begin
      $display("FAIL b2b_count: got %0d want 10", got); n_bad++;
    end
    drive0(1'b0, '0, '0, '0, '0, '0);
    drive1(1'b0, '0, '0, '0, '0, '0);
    repeat (3) tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive0(1'b1, 32'd9, 32'd1, FS_SUB, 5'd0, 4'd4);
    tick();
    req0_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_f} !== {1'b0, 32'd0}) begin
      $display("FAIL rst_in_resp: got %h want 0", {rsp_valid, rsp_f}); n_bad++;
    end
    tick();
    rst_n = 1'b1;
    drive1(1'b1, 32'd2, 32'd3, FS_ADD, 5'd0, 4'd7);
    rsp_ready = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      $display("FAIL rst_in_exec: got %b want 0", rsp_valid); n_bad++;
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      $display("FAIL rst_discard: got %b want 0", rsp_valid); n_bad++;
    end
    rst_n = 1'b1;
    tick();
    req1_valid = 1'b0;
    tick();
    n_cmp++;
    if (rsp_all !== {1'b1, 1'b1, 4'd7, 4'b0000, 1'b0, 1'b0, 32'd5}) begin
      $display("FAIL rst_reaccept_rsp: got %h want %h", rsp_all,
               {1'b1, 1'b1, 4'd7, 4'b0000, 1'b0, 1'b0, 32'd5}); n_bad++;
    end
    repeat (3) tick();
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      $display("FAIL rst_single_rsp: got %b want 0", rsp_valid); n_bad++;
    end
    rsp_ready = 1'b0;
  endtask

`ifdef FU_ARB_STICKY_FLAGS_EN
  task automatic test_sticky();
    do_reset();
    n_cmp++;
    if (sticky_vc !== 2'b00) begin
      $display("FAIL sticky_reset: got %b want 00", sticky_vc); n_bad++;
    end
    rsp_ready = 1'b1;
    drive0(1'b1, 32'h7FFF_FFFF, 32'd1, FS_ADD, 5'd0, 4'd1);
    tick();
    req0_valid = 1'b0;
    tick();
    n_cmp++;
    if (sticky_vc !== 2'b10) begin
      $display("FAIL sticky_set: got %b want 10", sticky_vc); n_bad++;
    end
    tick();
    drive0(1'b1, 32'hF0, 32'h0F, FS_AND, 5'd0, 4'd2);
    tick();
    req0_valid = 1'b0;
    tick();
    n_cmp++;
    if (sticky_vc !== 2'b10) begin
      $display("FAIL sticky_hold: got %b want 10", sticky_vc); n_bad++;
    end
    tick();
    drive0(1'b1, 32'h7FFF_FFFF, 32'd1, FS_ADD, 5'd0, 4'd3);
    tick();
    req0_valid = 1'b0;
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    n_cmp++;
    if (sticky_vc !== 2'b00) begin
      $display("FAIL sticky_clr_wins: got %b want 00", sticky_vc); n_bad++;
    end
    tick();
    rsp_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_contention();
    test_shift();
    test_stall();
    test_back_to_back();
    test_reset_mid();
`ifdef FU_ARB_STICKY_FLAGS_EN
    test_sticky();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule

`default_nettype wire
